alu_ctrl_fsm: RTL and testbench

//  Multi-cycle RV32I controller; drives the ALU's control inputs and consumes its 3-bit compare flags.

---
 rtl/alu_ctrl_fsm.sv | 190 +++++++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/exec/mem/wb
// and drives ALU operand/op selects plus PC, IR, RF and dmem enables.
module alu_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [2:0]  zero,
    input  logic        mem_ready,
    output logic        imem_re,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        aluout_we,
    output logic [1:0]  ALUSrc1,
    output logic [1:0]  ALUSrc2,
    output logic [2:0]  ALUOP,
    output logic        sp_sign,
    output logic        uors,
    output logic        dmem_re,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        err,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        is_r, is_i, is_ld, is_st, is_br;
    logic        is_jal, is_jalr, is_lui, is_auipc;
    logic        legal;
    logic [8:0]  cnt_inc;
    logic        tmo;
    logic        lt, eq, taken;
    logic        unused_bits;

    assign opc      = instr[6:0];
    assign f3       = instr[14:12];
    assign is_r     = (opc == 7'b0110011);
    assign is_i     = (opc == 7'b0010011);
    assign is_ld    = (opc == 7'b0000011);
    assign is_st    = (opc == 7'b0100011);
    assign is_br    = (opc == 7'b1100011);
    assign is_jal   = (opc == 7'b1101111);
    assign is_jalr  = (opc == 7'b1100111);
    assign is_lui   = (opc == 7'b0110111);
    assign is_auipc = (opc == 7'b0010111);
    assign legal    = is_r | is_i | is_ld | is_st | is_br
                    | is_jal | is_jalr | is_lui | is_auipc;

    assign unused_bits = ^{instr[31], instr[29:15], instr[11:7], zero[0]};

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign tmo     = (cnt_inc == 9'(TIMEOUT));

    // zero is {lt, eq, gt}; funct3[0] inverts the base condition
    assign lt    = zero[2];
    assign eq    = zero[1];
    assign taken = (f3[2] ? lt : eq) ^ f3[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        imem_re   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'b00;
        aluout_we = 1'b0;
        ALUSrc1   = 2'b00;
        ALUSrc2   = 2'b00;
        ALUOP     = 3'b000;
        sp_sign   = 1'b0;
        uors      = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 1'b0;
        // enables are forced low for as long as reset is held
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    imem_re = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end else if (tmo) begin
                        state_d = S_TRAP;
                    end
                end
                S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
                S_EXEC: begin
                    aluout_we = 1'b1;
                    pc_we     = 1'b1;
                    state_d   = S_WB;
                    unique case (1'b1)
                        is_r: begin
                            ALUOP   = f3;
                            sp_sign = instr[30] & (f3 == 3'b000 || f3 == 3'b101);
                        end
                        is_i: begin
                            ALUSrc1 = 2'b01;
                            ALUOP   = f3;
                            sp_sign = instr[30] & (f3 == 3'b101);
                        end
                        is_ld, is_st: begin
                            ALUSrc1 = 2'b01;
                            state_d = S_MEM;
                        end
                        is_br: begin
                            sp_sign = 1'b1;
                            uors    = f3[1];
                            pc_src  = taken ? 2'b01 : 2'b00;
                            state_d = S_FETCH;
                        end
                        is_jal, is_jalr: begin
                            ALUSrc2 = 2'b01;
                            ALUSrc1 = 2'b10;
                            pc_src  = is_jal ? 2'b01 : 2'b10;
                        end
                        is_lui: begin
                            ALUSrc2 = 2'b10;
                            ALUSrc1 = 2'b01;
                        end
                        is_auipc: begin
                            ALUSrc2 = 2'b01;
                            ALUSrc1 = 2'b01;
                        end
                        default: state_d = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    dmem_re = is_ld;
                    dmem_we = is_st;
                    if (mem_ready) begin
                        state_d = is_ld ? S_WB : S_FETCH;
                    end else if (tmo) begin
                        state_d = S_TRAP;
                    end
                end
                S_WB: begin
                    rf_we   = 1'b1;
                    wb_sel  = is_ld;
                    state_d = S_FETCH;
                end
                S_TRAP:  state_d = S_TRAP;
                default: state_d = S_TRAP;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
            cnt_d = cnt_inc[7:0];
        end
    end

    assign err_d   = err_q | (state_d == S_TRAP);
    assign err     = err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed bench for alu_ctrl_fsm: walks instruction classes, memory
// wait states, timeout, illegal opcode and async reset.
module tb_alu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [2:0]  zero;
    logic        mem_ready;
    logic        imem_re, ir_we, pc_we, aluout_we;
    logic [1:0]  pc_src, ALUSrc1, ALUSrc2;
    logic [2:0]  ALUOP;
    logic        sp_sign, uors, dmem_re, dmem_we, rf_we, wb_sel, err;
    logic [2:0]  state_o;

    int checks = 0;
    int errors = 0;

    alu_ctrl_fsm #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .mem_ready(mem_ready), .imem_re(imem_re), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .aluout_we(aluout_we),
        .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ALUOP(ALUOP),
        .sp_sign(sp_sign), .uors(uors), .dmem_re(dmem_re),
        .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel),
        .err(err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // from FETCH: fetch with zero wait, decode, land in EXEC
    task automatic to_exec(input logic [31:0] ins);
        instr     = ins;
        mem_ready = 1'b1;
        tick();
        tick();
        chk("exec_state", state_o, 3'd2);
    endtask

    initial begin
        rst = 1'b1; instr = '0; zero = '0; mem_ready = 1'b0;
        #2;
        chk("rst_state", state_o, 3'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_imem_re", imem_re, 1'b0);
        chk("rst_rf_we", rf_we, 1'b0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("fetch_imem_re", imem_re, 1'b1);

        // add x3,x1,x2
        instr = 32'h002081B3; mem_ready = 1'b1;
        #1;
        chk("fetch_ir_we", ir_we, 1'b1);
        tick();
        chk("add_decode", state_o, 3'd1);
        chk("decode_ir_we", ir_we, 1'b0);
        chk("decode_pc_we", pc_we, 1'b0);
        tick();
        chk("add_exec", state_o, 3'd2);
        chk("add_aluout_we", aluout_we, 1'b1);
        chk("add_pc_we", pc_we, 1'b1);
        chk("add_pc_src", pc_src, 2'b00);
        chk("add_aluop", ALUOP, 3'b000);
        chk("add_sp_sign", sp_sign, 1'b0);
        chk("add_src1", ALUSrc1, 2'b00);
        chk("add_src2", ALUSrc2, 2'b00);
        tick();
        chk("add_wb", state_o, 3'd4);
        chk("add_rf_we", rf_we, 1'b1);
        chk("add_wb_sel", wb_sel, 1'b0);
        chk("wb_pc_we", pc_we, 1'b0);
        tick();
        chk("add_fetch", state_o, 3'd0);
        chk("fetch_rf_we", rf_we, 1'b0);

        // srai
        to_exec(32'h4020D093);
        chk("srai_aluop", ALUOP, 3'b101);
        chk("srai_sp_sign", sp_sign, 1'b1);
        chk("srai_src1", ALUSrc1, 2'b01);
        tick();
        chk("srai_wb", state_o, 3'd4);
        tick();

        // addi with instr[30]=1
        to_exec(32'h40008093);
        chk("addi_aluop", ALUOP, 3'b000);
        chk("addi_sp_sign", sp_sign, 1'b0);
        chk("addi_src1", ALUSrc1, 2'b01);
        tick(); tick();

        // bltu taken
        zero = 3'b100;
        to_exec(32'h0020E063);
        chk("bltu_t_uors", uors, 1'b1);
        chk("bltu_t_sp_sign", sp_sign, 1'b1);
        chk("bltu_t_pc_we", pc_we, 1'b1);
        chk("bltu_t_pc_src", pc_src, 2'b01);
        tick();
        chk("bltu_t_fetch", state_o, 3'd0);

        // bltu not taken
        zero = 3'b010;
        to_exec(32'h0020E063);
        chk("bltu_n_pc_we", pc_we, 1'b1);
        chk("bltu_n_pc_src", pc_src, 2'b00);
        tick();
        chk("bltu_n_fetch", state_o, 3'd0);

        // bne with eq set: not taken, signed
        to_exec(32'h00209063);
        chk("bne_pc_src", pc_src, 2'b00);
        chk("bne_uors", uors, 1'b0);
        tick();

        // jal
        to_exec(32'h0000006F);
        chk("jal_src2", ALUSrc2, 2'b01);
        chk("jal_src1", ALUSrc1, 2'b10);
        chk("jal_pc_src", pc_src, 2'b01);
        tick();
        chk("jal_wb", state_o, 3'd4);
        tick();

        // jalr
        to_exec(32'h00008067);
        chk("jalr_pc_src", pc_src, 2'b10);
        chk("jalr_src1", ALUSrc1, 2'b10);
        tick(); tick();

        // lw with three wait cycles in MEM
        to_exec(32'h0000A083);
        chk("lw_src1", ALUSrc1, 2'b01);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_state", state_o, 3'd3);
            chk("lw_dmem_re", dmem_re, 1'b1);
            chk("lw_rf_we", rf_we, 1'b0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_dmem_re_last", dmem_re, 1'b1);
        tick();
        chk("lw_wb", state_o, 3'd4);
        chk("lw_wb_sel", wb_sel, 1'b1);
        chk("lw_rf_we_wb", rf_we, 1'b1);
        tick();
        chk("lw_fetch", state_o, 3'd0);

        // sw interrupted by async reset
        to_exec(32'h0020A023);
        mem_ready = 1'b0;
        tick();
        chk("sw_mem", state_o, 3'd3);
        chk("sw_dmem_we", dmem_we, 1'b1);
        chk("sw_dmem_re", dmem_re, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("sw_rst_dmem_we", dmem_we, 1'b0);
        chk("sw_rst_state", state_o, 3'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("sw_post_rst", state_o, 3'd0);

        // illegal opcode
        instr = 32'h0000007F; mem_ready = 1'b1;
        tick();
        chk("ill_decode", state_o, 3'd1);
        chk("ill_err_pre", err, 1'b0);
        tick();
        chk("ill_trap", state_o, 3'd7);
        chk("ill_err", err, 1'b1);
        chk("ill_imem_re", imem_re, 1'b0);
        tick();
        chk("ill_hold", state_o, 3'd7);
        rst = 1'b1;
        #1;
        chk("ill_rst_err", err, 1'b0);
        tick();
        rst = 1'b0;

        // fetch timeout
        mem_ready = 1'b0;
        repeat (254) tick();
        chk("tmo_254", state_o, 3'd0);
        chk("tmo_err_pre", err, 1'b0);
        tick();
        chk("tmo_trap", state_o, 3'd7);
        chk("tmo_err", err, 1'b1);
        chk("tmo_imem_re", imem_re, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
